// File: rtl/bit_manip_unit.sv
// ---------------------------------------------------------------------------
// bit_manip_unit
//
// Multi-cycle SET / RES / TGL / BIT unit for WIDTH-bit operands. A request is
// accepted in IDLE, the bit mask is registered in MASK, the result and flags
// are registered in EXEC, and they are presented in DONE until the consumer
// takes them over the valid/ready handshake.
//
// Optional build macro: BITMANIP_FIELD_EN
//   defined   -> mask is a contiguous field of len+1 bits starting at sel.
//                The field is truncated at bit WIDTH-1 and does not wrap.
//   undefined -> mask is the single bit sel, and len has no effect.
//   The port list is the same in both builds.
//
// Ports
//   clk        in   system clock, rising edge
//   nreset     in   synchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  unit idle and able to accept a request
//   op         in   0=SET 1=RES 2=TGL 3=BIT
//   sel        in   bit index (field start)
//   len        in   field length minus one (field build only)
//   operand    in   source value
//   carry_in   in   current carry flag, passed through on BIT
//   out_valid  out  result/flags valid
//   out_ready  in   consumer takes the result
//   result     out  operation result
//   zero       out  Z flag
//   carry      out  C flag
//   half       out  H flag
//   busy       out  a request is in flight
// ---------------------------------------------------------------------------
module bit_manip_unit #(
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [SELW-1:0]  sel,
    input  logic [SELW-1:0]  len,
    input  logic [WIDTH-1:0] operand,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             half,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MASK = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_RES = 2'd1;
    localparam logic [1:0] OP_TGL = 2'd2;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_op;
    logic [SELW-1:0]    r_sel;
    logic [SELW-1:0]    r_len;
    logic [WIDTH-1:0]   r_operand;
    logic               r_carry_in;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_half;

    logic [SELW-1:0]    w_len_eff;
    logic [SELW:0]      w_hi;
    logic [WIDTH-1:0]   w_mask;
    logic [WIDTH-1:0]   w_result;
    logic               w_zero;
    logic               w_carry;
    logic               w_half;

    // ------------------------------------------------------------------
    // Mask generator. Both builds share one range decoder: bit gi is set
    // when sel <= gi <= sel+len_eff. With a single-bit mask len_eff is
    // forced to zero. Indices at or above WIDTH simply have no mask bit,
    // which gives truncation without wrap and m=0 for an out-of-range sel.
    // ------------------------------------------------------------------
`ifdef BITMANIP_FIELD_EN
    assign w_len_eff = r_len;
`else
    assign w_len_eff = r_len & {SELW{1'b0}};
`endif

    // One extra bit so sel+len never wraps back into the operand range.
    assign w_hi = {1'b0, r_sel} + {1'b0, w_len_eff};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign w_mask[gi] = (gi >= int'(r_sel)) && (gi <= int'(w_hi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Execute datapath, consumed in EXEC from the registered mask.
    // ------------------------------------------------------------------
    always_comb begin
        w_result = r_operand;
        w_zero   = 1'b0;
        w_carry  = 1'b0;
        w_half   = 1'b0;
        case (r_op)
            OP_SET: w_result = r_operand | r_mask;
            OP_RES: w_result = r_operand & ~r_mask;
            OP_TGL: w_result = r_operand ^ r_mask;
            default: begin
                // BIT: operand passes through, Z reflects the tested bits.
                w_result = r_operand;
                w_half   = 1'b1;
                w_carry  = r_carry_in;
            end
        endcase
        if (r_op == 2'd3) begin
            w_zero = ((r_operand & r_mask) == '0);
        end else begin
            w_zero = (w_result == '0);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = S_MASK;
            S_MASK: w_state_next = S_EXEC;
            S_EXEC: w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_sel      <= '0;
            r_len      <= '0;
            r_operand  <= '0;
            r_carry_in <= 1'b0;
            r_mask     <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_half     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && in_valid) begin
                r_op       <= op;
                r_sel      <= sel;
                r_len      <= len;
                r_operand  <= operand;
                r_carry_in <= carry_in;
            end
            if (r_state == S_MASK) begin
                r_mask <= w_mask;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_result;
                r_zero   <= w_zero;
                r_carry  <= w_carry;
                r_half   <= w_half;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign half      = r_half;

endmodule
